// File: rtl/dsp48a1_dot_pkg.sv
// Shared constants for the DSP48A1 dot-product sequencer: operand widths, OPMODE codes, FSM states.
// FIRST/ACC carry the pre-adder select bit when DSP48A1_DOT_SEQ_PREADD_EN is defined.
package dsp48a1_dot_pkg;

  localparam int DATA_W = 18;
  localparam int ACC_W  = 48;
  localparam int OPM_W  = 8;

`ifdef DSP48A1_DOT_SEQ_PREADD_EN
  localparam logic [OPM_W-1:0] OPM_FIRST = 8'b0001_0001;
  localparam logic [OPM_W-1:0] OPM_ACC   = 8'b0001_1001;
`else
  localparam logic [OPM_W-1:0] OPM_FIRST = 8'b0000_0001;
  localparam logic [OPM_W-1:0] OPM_ACC   = 8'b0000_1001;
`endif
  localparam logic [OPM_W-1:0] OPM_HOLD  = 8'b0000_1000;
  localparam logic [OPM_W-1:0] OPM_IDLE  = 8'b0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_HOLD
  } state_t;

endpackage

// File: rtl/dsp48a1_opm_delay.sv
// OPMODE shift register: delays each launched code so it meets M at the slice post-adder.
module dsp48a1_opm_delay
  import dsp48a1_dot_pkg::*;
#(
  parameter int OPM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPM_W-1:0] opm_in,
  output logic [OPM_W-1:0] opm_out
);

  logic [OPM_W-1:0] opm_p1 [OPM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OPM_LAT; i++) opm_p1[i] <= OPM_IDLE;
    end else begin
      opm_p1[0] <= opm_in;
      for (int i = 1; i < OPM_LAT; i++) opm_p1[i] <= opm_p1[i-1];
    end
  end

  assign opm_out = opm_p1[OPM_LAT-1];

endmodule

// File: rtl/dsp48a1_dot_seq.sv
// Dot-product sequencer: steers a DSP48A1 slice to accumulate sum(A*B) and returns the captured P.
// Optional pre-adder path (IN_D/DSP_D, term A*(D+B)) is enabled by DSP48A1_DOT_SEQ_PREADD_EN.
module dsp48a1_dot_seq
  import dsp48a1_dot_pkg::*;
#(
  parameter int P_LAT   = 3,
  parameter int OPM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_A,
  input  logic [DATA_W-1:0] IN_B,
  input  logic              IN_LAST,
`ifdef DSP48A1_DOT_SEQ_PREADD_EN
  input  logic [DATA_W-1:0] IN_D,
  output logic [DATA_W-1:0] DSP_D,
`endif
  output logic [DATA_W-1:0] DSP_A,
  output logic [DATA_W-1:0] DSP_B,
  output logic [OPM_W-1:0]  DSP_OPMODE,
  output logic              DSP_CE,
  output logic              DSP_RST,
  input  logic [ACC_W-1:0]  DSP_P,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [ACC_W-1:0]  RES_P,
  output logic [CNT_W-1:0]  RES_CNT
);

  localparam int DCW = (P_LAT < 1) ? 1 : $clog2(P_LAT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state, state_nxt;
  logic [DCW-1:0]   drain_cnt;
  logic [OPM_W-1:0] code_nxt, code_p0;
  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic [ACC_W-1:0] res_p;
  logic [CNT_W-1:0] res_cnt;
  logic             ce, dsp_rst;
  logic             xfer;

  assign IN_READY = !RST && (state == S_IDLE || state == S_ACC);
  assign xfer     = IN_VALID && IN_READY;

  always_comb begin
    state_nxt = state;
    code_nxt  = OPM_IDLE;
    case (state)
      S_IDLE: begin
        if (xfer) begin
          code_nxt  = OPM_FIRST;
          state_nxt = IN_LAST ? S_DRAIN : S_ACC;
        end
      end
      S_ACC: begin
        if (xfer) begin
          code_nxt = OPM_ACC;
          if (IN_LAST) state_nxt = S_DRAIN;
        end else begin
          // Bubble: keep P unchanged so gaps in the stream do not disturb the sum.
          code_nxt = OPM_HOLD;
        end
      end
      S_DRAIN: begin
        code_nxt = OPM_HOLD;
        if (drain_cnt == '0) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (RES_READY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: operand/code launch into the slice, control state, result capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      code_p0   <= OPM_IDLE;
      a_p0      <= '0;
      b_p0      <= '0;
      res_p     <= '0;
      res_cnt   <= '0;
      ce        <= 1'b0;
    end else begin
      state   <= state_nxt;
      code_p0 <= code_nxt;
      ce      <= 1'b1;
      if (xfer) begin
        a_p0    <= IN_A;
        b_p0    <= IN_B;
        res_cnt <= (state == S_IDLE) ? {{(CNT_W-1){1'b0}}, 1'b1} : sat_inc(res_cnt);
      end
      // Counter is preloaded outside S_DRAIN, so it starts at P_LAT on entry.
      if (state != S_DRAIN) drain_cnt <= DCW'(P_LAT);
      else if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      if (state == S_DRAIN && drain_cnt == '0) res_p <= DSP_P;
    end
  end

  always_ff @(posedge CLK) begin
    dsp_rst <= RST;
  end

`ifdef DSP48A1_DOT_SEQ_PREADD_EN
  logic signed [DATA_W-1:0] d_p0;

  always_ff @(posedge CLK) begin
    if (RST) d_p0 <= '0;
    else if (xfer) d_p0 <= IN_D;
  end

  assign DSP_D = d_p0;
`endif

  // Stage p1..: OPMODE trails the operands so it lines up with M inside the slice
  dsp48a1_opm_delay #(
    .OPM_LAT(OPM_LAT)
  ) u_opm_delay (
    .clk    (CLK),
    .rst    (RST),
    .opm_in (code_p0),
    .opm_out(DSP_OPMODE)
  );

  assign DSP_A     = a_p0;
  assign DSP_B     = b_p0;
  assign DSP_CE    = ce;
  assign DSP_RST   = dsp_rst;
  assign RES_VALID = (state == S_HOLD);
  assign RES_P     = res_p;
  assign RES_CNT   = res_cnt;

endmodule
